hud_stats_ctrl: RTL and testbench
=================================

// Module: hud_stats_ctrl
// PURPOSE
//  Owns and sequences the HUD game statistics: lives, BCD level, BCD score and the pre-level countdown.
//  Drives the packed display inputs consumed by the HUD digit-vector/number-drawing path.
//  Runs the game-phase FSM (IDLE/COUNTDOWN/PLAY/OVER) and gates gameplay via playEnable.
//  Performs multi-cycle BCD score accumulation behind a ready/valid handshake.
// PARAMETERS
//  SCORE_DIGITS     3  BCD digits of score (scoreDisplay width = 4*SCORE_DIGITS)
//  INIT_LIVES       3  lives loaded at reset/game start (1..MAX_LIVES)
//  MAX_LIVES        9  lives saturation value (<=9, single BCD digit)
//  COUNTDOWN_START  5  countdown reload value (1..9)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  startGame        in   1   pulse: (re)start game, reload all stats
//  oneSecPulse      in   1   1-cycle tick, once per second
//  levelUp          in   1   pulse: level cleared
//  lifeLost         in   1   pulse: player hit
//  lifeGained       in   1   pulse: bonus life
//  scoreValid       in   1   score-add request
//  scoreAmount      in   4   points to add (BCD 0..9; values >9 clamp to 9)
//  scoreReady       out  1   adder can accept request this cycle
//  livesDisplay     out  4   lives, BCD
//  levelDisplay     out  8   level, 2 BCD digits {tens,units}
//  scoreDisplay     out  12  score, SCORE_DIGITS BCD digits, units in [3:0]
//  countdownDisplay out  4   countdown digit, BCD
//  playEnable       out  1   high only in PLAY
//  gameOver         out  1   high only in OVER
// BEHAVIOUR
//  Reset (async): state=IDLE, lives=INIT_LIVES, level=8'h01, score=0, countdown=COUNTDOWN_START,
//   adder idle, scoreReady=0, playEnable=0, gameOver=0. All outputs registered.
//  FSM:
//   IDLE      -> COUNTDOWN on startGame (reload lives/level/score/countdown).
//   COUNTDOWN -> on oneSecPulse: if countdown==0 go PLAY, else countdown-1.
//   PLAY      -> levelUp: level+1 BCD (saturate at 99), countdown reload, go COUNTDOWN.
//                lifeLost: lives-1; if lives was 1 -> lives=0, go OVER.
//                lifeGained: lives+1, saturate at MAX_LIVES.
//   OVER      -> COUNTDOWN on startGame (full reload).
//  startGame in COUNTDOWN/PLAY: full reload, go COUNTDOWN, in-flight score add aborted (no commit).
//  Same-cycle priority in PLAY: startGame > lifeLost > levelUp. lifeLost+lifeGained same cycle:
//   lives unchanged. lifeLost+levelUp: only lifeLost applied. Life/level events ignored outside PLAY.
//  Score adder: scoreReady = (state==PLAY) && adder idle. Accept when scoreValid && scoreReady (cycle N).
//   Cycles N+1..N+SCORE_DIGITS: one digit per cycle, units first, into a working copy:
//   s = digit + carry_in (+amount on digit 0); if s>9: digit=s-10, carry=1.
//   Commit working copy to scoreDisplay at end of cycle N+SCORE_DIGITS; scoreReady high again in
//   cycle N+SCORE_DIGITS+1. Carry out of top digit -> score saturates to all 9s.
//   If PLAY is left mid-add (OVER or COUNTDOWN via levelUp), the add completes and commits;
//   only startGame or reset aborts it. scoreValid while !scoreReady is ignored, not queued.
//  Reset mid-operation: immediate return to reset values, including mid-add.
// TESTING
//  reset; startGame; 6 oneSecPulse -> countdown 5,4,3,2,1,0 then PLAY, playEnable=1.
//  PLAY score=099, add 1 -> scoreReady low 3 cycles, scoreDisplay=12'h100 on cycle N+3 only.
//  score=995, add 9 -> score=999 (saturate); scoreAmount=4'hC -> treated as 9.
//  lives=1, lifeLost+lifeGained same cycle -> lives=1; then lifeLost -> lives=0, gameOver=1.
//  level=8'h09 levelUp -> 8'h10, COUNTDOWN reload=5; level 8'h99 levelUp -> stays 8'h99.
//  startGame asserted one cycle after score accept -> score=0, no late commit; reset mid-add -> all reset values.

Source files
------------

// File: rtl/hud_stats_if.sv
// hud_stats_if
//  Bundles the HUD statistics block's game-event inputs, the score-add
//  ready/valid handshake and the packed display outputs.
//  master : game logic / testbench side (drives events and score requests)
//  slave  : hud_stats_ctrl side (drives displays, scoreReady and phase flags)
interface hud_stats_if #(
  parameter int SCORE_DIGITS = 3
);
  logic                      startGame;
  logic                      oneSecPulse;
  logic                      levelUp;
  logic                      lifeLost;
  logic                      lifeGained;
  logic                      scoreValid;
  logic [3:0]                scoreAmount;
  logic                      scoreReady;
  logic [3:0]                livesDisplay;
  logic [7:0]                levelDisplay;
  logic [4*SCORE_DIGITS-1:0] scoreDisplay;
  logic [3:0]                countdownDisplay;
  logic                      playEnable;
  logic                      gameOver;

  modport master (
    output startGame, oneSecPulse, levelUp, lifeLost, lifeGained,
           scoreValid, scoreAmount,
    input  scoreReady, livesDisplay, levelDisplay, scoreDisplay,
           countdownDisplay, playEnable, gameOver
  );

  modport slave (
    input  startGame, oneSecPulse, levelUp, lifeLost, lifeGained,
           scoreValid, scoreAmount,
    output scoreReady, livesDisplay, levelDisplay, scoreDisplay,
           countdownDisplay, playEnable, gameOver
  );
endinterface

// File: rtl/hud_stats_ctrl.sv
// hud_stats_ctrl
//  Owns the HUD game statistics (lives, BCD level, BCD score, pre-level
//  countdown), runs the IDLE/COUNTDOWN/PLAY/OVER game-phase FSM and performs
//  a digit-serial BCD score add behind a ready/valid handshake.
//  Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - hud_stats_if.slave: event pulses, score request, display outputs
//  All outputs come straight from flops.
module hud_stats_ctrl #(
  parameter int SCORE_DIGITS    = 3,
  parameter int INIT_LIVES      = 3,
  parameter int MAX_LIVES       = 9,
  parameter int COUNTDOWN_START = 5
) (
  input  logic        clk,
  input  logic        reset,
  hud_stats_if.slave  bus
);
  localparam int SW = 4 * SCORE_DIGITS;
  localparam int IW = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, COUNTDOWN, PLAY, OVER} state_e;

  localparam logic [SW-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

  state_e          state_q, state_d;
  logic [3:0]      lives_q, lives_d;
  logic [7:0]      level_q, level_d;
  logic [SW-1:0]   score_q, score_d;
  logic [3:0]      cnt_q, cnt_d;
  // adder working state
  logic            busy_q, busy_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [3:0]      amt_q, amt_d;
  logic [SW-1:0]   work_q, work_d;
  // registered outputs
  logic            ready_q, ready_d;
  logic            play_q, play_d;
  logic            over_q, over_d;

  logic [3:0]      dig;
  logic [4:0]      sum;
  logic [3:0]      new_dig;
  logic            new_carry;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    amt_d     = amt_q;
    work_d    = work_q;
    dig       = '0;
    sum       = '0;
    new_dig   = '0;
    new_carry = 1'b0;

    // One BCD digit per cycle, units first. Runs regardless of game phase so
    // an add started in PLAY still commits after the phase changes.
    if (busy_q) begin
      dig = work_q[idx_q*4 +: 4];
      sum = 5'(dig) + 5'(carry_q) + ((idx_q == '0) ? 5'(amt_q) : 5'd0);
      if (sum > 5'd9) begin
        new_dig   = 4'(sum - 5'd10);
        new_carry = 1'b1;
      end else begin
        new_dig   = sum[3:0];
        new_carry = 1'b0;
      end
      work_d[idx_q*4 +: 4] = new_dig;
      carry_d              = new_carry;
      if (idx_q == IW'(SCORE_DIGITS - 1)) begin
        busy_d  = 1'b0;
        // carry out of the top digit means overflow: pin at all nines
        score_d = new_carry ? SCORE_MAX : work_d;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (ready_q && bus.scoreValid) begin
      busy_d  = 1'b1;
      idx_d   = '0;
      carry_d = 1'b0;
      work_d  = score_q;
      amt_d   = (bus.scoreAmount > 4'd9) ? 4'd9 : bus.scoreAmount;
    end

    case (state_q)
      COUNTDOWN: begin
        if (bus.oneSecPulse) begin
          if (cnt_q == 4'd0) state_d = PLAY;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      PLAY: begin
        if (bus.lifeLost) begin
          // lifeLost wins over levelUp; paired with lifeGained it cancels out
          if (!bus.lifeGained) begin
            if (lives_q <= 4'd1) begin
              lives_d = 4'd0;
              state_d = OVER;
            end else begin
              lives_d = lives_q - 4'd1;
            end
          end
        end else begin
          if (bus.lifeGained && (lives_q < 4'(MAX_LIVES)))
            lives_d = lives_q + 4'd1;
          if (bus.levelUp) begin
            if (level_q != 8'h99) begin
              if (level_q[3:0] == 4'h9) level_d = {level_q[7:4] + 4'd1, 4'h0};
              else                      level_d = {level_q[7:4], level_q[3:0] + 4'd1};
            end
            cnt_d   = 4'(COUNTDOWN_START);
            state_d = COUNTDOWN;
          end
        end
      end
      default: ; // IDLE / OVER wait for startGame
    endcase

    // startGame overrides everything, including any in-flight add
    if (bus.startGame) begin
      state_d = COUNTDOWN;
      lives_d = 4'(INIT_LIVES);
      level_d = 8'h01;
      score_d = '0;
      cnt_d   = 4'(COUNTDOWN_START);
      busy_d  = 1'b0;
    end

    ready_d = (state_d == PLAY) && !busy_d;
    play_d  = (state_d == PLAY);
    over_d  = (state_d == OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lives_q <= 4'(INIT_LIVES);
      level_q <= 8'h01;
      score_q <= '0;
      cnt_q   <= 4'(COUNTDOWN_START);
      busy_q  <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      amt_q   <= '0;
      work_q  <= '0;
      ready_q <= 1'b0;
      play_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      amt_q   <= amt_d;
      work_q  <= work_d;
      ready_q <= ready_d;
      play_q  <= play_d;
      over_q  <= over_d;
    end
  end

  assign bus.scoreReady       = ready_q;
  assign bus.livesDisplay     = lives_q;
  assign bus.levelDisplay     = level_q;
  assign bus.scoreDisplay     = score_q;
  assign bus.countdownDisplay = cnt_q;
  assign bus.playEnable       = play_q;
  assign bus.gameOver         = over_q;
endmodule

// File: tb/tb_hud_stats_ctrl.sv
// tb_hud_stats_ctrl
//  Directed bench for hud_stats_ctrl: linear sequence of steps, each
//  comparison an immediate assertion against hand-derived values.
module tb_hud_stats_ctrl;
  logic clk;
  logic reset;
  int   nchk;
  int   nerr;

  hud_stats_if #(.SCORE_DIGITS(3)) bus ();

  hud_stats_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.startGame = 1'b1; step(); bus.startGame = 1'b0;
  endtask

  task automatic pulse_sec();
    bus.oneSecPulse = 1'b1; step(); bus.oneSecPulse = 1'b0;
  endtask

  task automatic pulse_level();
    bus.levelUp = 1'b1; step(); bus.levelUp = 1'b0;
  endtask

  task automatic run_countdown();
    for (int i = 0; i < 6; i++) pulse_sec();
  endtask

  // wait (bounded) for scoreReady, issue one add, let it run to commit
  task automatic add(input logic [3:0] amt);
    int w;
    w = 0;
    while (bus.scoreReady !== 1'b1 && w < 10) begin step(); w++; end
    if (bus.scoreReady !== 1'b1) chk("ready_timeout", {31'd0, bus.scoreReady}, 32'd1);
    bus.scoreValid = 1'b1; bus.scoreAmount = amt;
    step();
    bus.scoreValid = 1'b0; bus.scoreAmount = 4'd0;
    step(); step(); step();
  endtask

  initial begin
    nchk = 0; nerr = 0;
    reset = 1'b1;
    bus.startGame = 0; bus.oneSecPulse = 0; bus.levelUp = 0;
    bus.lifeLost = 0; bus.lifeGained = 0; bus.scoreValid = 0; bus.scoreAmount = 0;
    step(); step();
    chk("rst_lives", {28'd0, bus.livesDisplay}, 32'd3);
    chk("rst_level", {24'd0, bus.levelDisplay}, 32'h01);
    chk("rst_score", {20'd0, bus.scoreDisplay}, 32'h000);
    chk("rst_cnt",   {28'd0, bus.countdownDisplay}, 32'd5);
    chk("rst_ready", {31'd0, bus.scoreReady}, 32'd0);
    chk("rst_play",  {31'd0, bus.playEnable}, 32'd0);
    chk("rst_over",  {31'd0, bus.gameOver}, 32'd0);
    reset = 1'b0;
    step();

    // start + countdown 5..0 then PLAY
    pulse_start();
    chk("cd_start", {28'd0, bus.countdownDisplay}, 32'd5);
    for (int i = 0; i < 5; i++) begin
      pulse_sec();
      chk("cd_step", {28'd0, bus.countdownDisplay}, 32'(4 - i));
      chk("cd_noplay", {31'd0, bus.playEnable}, 32'd0);
    end
    pulse_sec();
    chk("cd_play", {31'd0, bus.playEnable}, 32'd1);
    chk("cd_ready", {31'd0, bus.scoreReady}, 32'd1);

    // clamp: 0xC adds as 9
    add(4'hC);
    chk("clamp", {20'd0, bus.scoreDisplay}, 32'h009);
    for (int i = 0; i < 10; i++) add(4'd9);
    chk("score99", {20'd0, bus.scoreDisplay}, 32'h099);

    // 099 + 1: ready low 3 cycles, commit after cycle N+3
    bus.scoreValid = 1'b1; bus.scoreAmount = 4'd1;
    step();
    bus.scoreValid = 1'b0; bus.scoreAmount = 4'd0;
    chk("carry_rdy1", {31'd0, bus.scoreReady}, 32'd0);
    step();
    chk("carry_rdy2", {31'd0, bus.scoreReady}, 32'd0);
    chk("carry_pre",  {20'd0, bus.scoreDisplay}, 32'h099);
    step();
    chk("carry_rdy3", {31'd0, bus.scoreReady}, 32'd0);
    chk("carry_pre2", {20'd0, bus.scoreDisplay}, 32'h099);
    step();
    chk("carry_val",  {20'd0, bus.scoreDisplay}, 32'h100);
    chk("carry_rdy4", {31'd0, bus.scoreReady}, 32'd1);

    // climb to 995 (100 + 99*9 + 4), then saturate
    for (int i = 0; i < 99; i++) add(4'd9);
    add(4'd4);
    chk("score995", {20'd0, bus.scoreDisplay}, 32'h995);
    add(4'd9);
    chk("sat999", {20'd0, bus.scoreDisplay}, 32'h999);
    add(4'hC);
    chk("sat999b", {20'd0, bus.scoreDisplay}, 32'h999);

    // lives saturation at 9
    bus.lifeGained = 1'b1;
    for (int i = 0; i < 7; i++) step();
    bus.lifeGained = 1'b0;
    chk("lives9", {28'd0, bus.livesDisplay}, 32'd9);
    bus.lifeGained = 1'b1; step(); bus.lifeGained = 1'b0;
    chk("lives_sat", {28'd0, bus.livesDisplay}, 32'd9);
    // lifeLost + levelUp: only the life is lost
    bus.lifeLost = 1'b1; bus.levelUp = 1'b1; step();
    bus.lifeLost = 1'b0; bus.levelUp = 1'b0;
    chk("ll_lv_lives", {28'd0, bus.livesDisplay}, 32'd8);
    chk("ll_lv_level", {24'd0, bus.levelDisplay}, 32'h01);
    chk("ll_lv_play",  {31'd0, bus.playEnable}, 32'd1);

    // levels 01 -> 09
    for (int i = 0; i < 8; i++) begin pulse_level(); run_countdown(); end
    chk("level09", {24'd0, bus.levelDisplay}, 32'h09);
    pulse_level();
    chk("level10", {24'd0, bus.levelDisplay}, 32'h10);
    chk("lv_cnt",  {28'd0, bus.countdownDisplay}, 32'd5);
    chk("lv_noplay", {31'd0, bus.playEnable}, 32'd0);
    // events ignored outside PLAY
    bus.lifeLost = 1'b1; step(); bus.lifeLost = 1'b0;
    chk("cd_ignore", {28'd0, bus.livesDisplay}, 32'd8);
    run_countdown();
    for (int i = 0; i < 89; i++) begin pulse_level(); run_countdown(); end
    chk("level99", {24'd0, bus.levelDisplay}, 32'h99);
    pulse_level();
    chk("level99s", {24'd0, bus.levelDisplay}, 32'h99);
    run_countdown();
    chk("lv_score", {20'd0, bus.scoreDisplay}, 32'h999);

    // lives down to 1, then lost+gained cancel, then game over
    bus.lifeLost = 1'b1;
    for (int i = 0; i < 7; i++) step();
    bus.lifeLost = 1'b0;
    chk("lives1", {28'd0, bus.livesDisplay}, 32'd1);
    bus.lifeLost = 1'b1; bus.lifeGained = 1'b1; step();
    bus.lifeLost = 1'b0; bus.lifeGained = 1'b0;
    chk("ll_lg", {28'd0, bus.livesDisplay}, 32'd1);
    bus.lifeLost = 1'b1; step(); bus.lifeLost = 1'b0;
    chk("over_lives", {28'd0, bus.livesDisplay}, 32'd0);
    chk("over_flag",  {31'd0, bus.gameOver}, 32'd1);
    chk("over_play",  {31'd0, bus.playEnable}, 32'd0);

    // restart from OVER, abort an add with startGame
    pulse_start();
    chk("rs_lives", {28'd0, bus.livesDisplay}, 32'd3);
    chk("rs_level", {24'd0, bus.levelDisplay}, 32'h01);
    chk("rs_score", {20'd0, bus.scoreDisplay}, 32'h000);
    chk("rs_over",  {31'd0, bus.gameOver}, 32'd0);
    run_countdown();
    bus.scoreValid = 1'b1; bus.scoreAmount = 4'd7; step();
    bus.scoreValid = 1'b0; bus.scoreAmount = 4'd0;
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    chk("abort_score", {20'd0, bus.scoreDisplay}, 32'h000);
    chk("abort_cnt",   {28'd0, bus.countdownDisplay}, 32'd5);

    // reset in the middle of an add
    run_countdown();
    add(4'd3);
    bus.lifeGained = 1'b1; step(); bus.lifeGained = 1'b0;
    bus.scoreValid = 1'b1; bus.scoreAmount = 4'd5; step();
    bus.scoreValid = 1'b0; bus.scoreAmount = 4'd0;
    step();
    reset = 1'b1;
    #1;
    chk("mr_score", {20'd0, bus.scoreDisplay}, 32'h000);
    chk("mr_lives", {28'd0, bus.livesDisplay}, 32'd3);
    chk("mr_ready", {31'd0, bus.scoreReady}, 32'd0);
    chk("mr_play",  {31'd0, bus.playEnable}, 32'd0);
    chk("mr_cnt",   {28'd0, bus.countdownDisplay}, 32'd5);
    step(); step();
    reset = 1'b0;
    step(); step(); step(); step();
    chk("mr_nocommit", {20'd0, bus.scoreDisplay}, 32'h000);
    chk("mr_idle", {31'd0, bus.playEnable}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
